// File: rtl/mag_pkg.sv
// Shared definitions for the windowed min/max tracker: state encoding and
// default build sizes.
package mag_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_WINDOW = 8;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ACCUM = ST_ACCUM,
    HOLD  = ST_HOLD
  } mag_state_e;

endpackage

// File: rtl/mag_cmp.sv
// Unsigned magnitude comparator; exactly one of eq/gt/lt is high for a vs b.
module mag_cmp #(
  parameter int WIDTH = 4
) (
  output logic             eq,
  output logic             gt,
  output logic             lt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/mag_window_minmax.sv
// Streaming min/max tracker: reports max, min, first-occurrence indices and
// the max tie count once per WINDOW accepted samples, held until taken.
//
//   state | meaning
//   IDLE  | no sample of the current window held
//   ACCUM | 1..WINDOW-1 samples held
//   HOLD  | result pending on the res_* handshake
module mag_window_minmax
  import mag_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WINDOW = DEF_WINDOW,
  parameter int IDX_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_max,
  output logic [WIDTH-1:0] res_min,
  output logic [IDX_W-1:0] res_max_idx,
  output logic [IDX_W-1:0] res_min_idx,
  output logic [CNT_W-1:0] res_max_ties
);

  mag_state_e state_q, state_d;

  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] cur_max, cur_min;
  logic [IDX_W-1:0] cur_max_idx, cur_min_idx;
  logic [CNT_W-1:0] cur_ties;

  logic             eq_max, gt_max, lt_max;
  logic             eq_min, gt_min, lt_min;
  logic             accept, first, last;
  logic [WIDTH-1:0] nxt_max, nxt_min;
  logic [IDX_W-1:0] nxt_max_idx, nxt_min_idx;
  logic [CNT_W-1:0] nxt_ties, nxt_count;

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_max (
    .eq(eq_max), .gt(gt_max), .lt(lt_max), .a(in_data), .b(cur_max)
  );

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_min (
    .eq(eq_min), .gt(gt_min), .lt(lt_min), .a(in_data), .b(cur_min)
  );

  // Only gt/eq vs max and lt vs min steer the update.
  logic unused_cmp;
  assign unused_cmp = &{1'b0, lt_max, eq_min, gt_min};

  assign in_ready  = (state_q != HOLD);
  assign res_valid = (state_q == HOLD);
  assign accept    = in_valid & in_ready;
  assign first     = (state_q == IDLE);

  always_comb begin
    nxt_max     = cur_max;
    nxt_min     = cur_min;
    nxt_max_idx = cur_max_idx;
    nxt_min_idx = cur_min_idx;
    nxt_ties    = cur_ties;
    nxt_count   = count + 1'b1;
    if (first) begin
      nxt_max     = in_data;
      nxt_min     = in_data;
      nxt_max_idx = '0;
      nxt_min_idx = '0;
      nxt_ties    = CNT_W'(1);
      nxt_count   = CNT_W'(1);
    end else begin
      if (gt_max) begin
        nxt_max     = in_data;
        nxt_max_idx = count[IDX_W-1:0];
        nxt_ties    = CNT_W'(1);
      end else if (eq_max) begin
        nxt_ties = cur_ties + 1'b1;
      end
      if (lt_min) begin
        nxt_min     = in_data;
        nxt_min_idx = count[IDX_W-1:0];
      end
    end
  end

  assign last = (nxt_count == CNT_W'(WINDOW));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = last ? HOLD : ACCUM;
      ACCUM:   if (accept && last) state_d = HOLD;
      HOLD:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      cur_max      <= '0;
      cur_min      <= '0;
      cur_max_idx  <= '0;
      cur_min_idx  <= '0;
      cur_ties     <= '0;
      res_max      <= '0;
      res_min      <= '0;
      res_max_idx  <= '0;
      res_min_idx  <= '0;
      res_max_ties <= '0;
    end else if (clear) begin
      count    <= '0;
      cur_ties <= '0;
    end else if (accept) begin
      cur_max     <= nxt_max;
      cur_min     <= nxt_min;
      cur_max_idx <= nxt_max_idx;
      cur_min_idx <= nxt_min_idx;
      cur_ties    <= nxt_ties;
      count       <= last ? '0 : nxt_count;
      if (last) begin
        res_max      <= nxt_max;
        res_min      <= nxt_min;
        res_max_idx  <= nxt_max_idx;
        res_min_idx  <= nxt_min_idx;
        res_max_ties <= nxt_ties;
      end
    end
  end

endmodule

// File: doc/mag_window_minmax.md
Name: mag_window_minmax

Overview:
- Streaming min/max tracker that sits directly downstream of the magnitude comparator.
- Accepts a stream of unsigned WIDTH-bit samples over a valid/ready handshake and compares each sample against the running max and min using comparator instances (eq/gt/lt outputs).
- After every WINDOW accepted samples it presents max, min, their first-occurrence indices and the number of samples equal to the max on a held result handshake.

Parameters:
- WIDTH, 4: sample width in bits, unsigned.
- WINDOW, 8: samples per result window; legal range 1..256.
- IDX_W, max(1,$clog2(WINDOW)): width of the index outputs.
- CNT_W, $clog2(WINDOW+1): width of the sample and tie counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; discards the partial window or pending result.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  WIDTH  sample.
- res_valid  out  1  result fields are valid and held.
- res_ready  in  1  consumer takes the result.
- res_max  out  WIDTH  largest sample in the window.
- res_min  out  WIDTH  smallest sample in the window.
- res_max_idx  out  IDX_W  index (0-based, acceptance order) of the first occurrence of the max.
- res_min_idx  out  IDX_W  index of the first occurrence of the min.
- res_max_ties  out  CNT_W  count of samples equal to res_max.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - All registers and outputs are 0, except in_ready=1.
  - Reset mid-window or mid-HOLD discards everything.
- States:
  - IDLE: no sample held.
  - ACCUM: 1..WINDOW-1 samples held.
  - HOLD: result pending.
- in_ready = (state != HOLD). It is combinational from state only and never depends on in_valid.
- Accept = in_valid & in_ready, sampled at the rising edge. Accepted index = the current count.
- First accept of a window (IDLE):
  - max=min=in_data, both indices=0, ties=1, count=1.
  - Next state: ACCUM, or HOLD if WINDOW=1.
- Later accepts (ACCUM), using comparators in_data vs max and in_data vs min:
  - gt vs max: max=in_data, max_idx=count, ties=1.
  - eq vs max: ties+=1; max and max_idx unchanged, so the first occurrence wins.
  - lt vs min: min=in_data, min_idx=count.
  - eq or gt vs min: min unchanged.
  - count+=1.
  - When the accepted sample is index WINDOW-1, next state is HOLD.
- Latency: res_valid rises the cycle after the WINDOW-th sample is accepted.
- HOLD:
  - res_valid=1; all res_* fields stable.
  - No sample is accepted.
  - On res_ready=1: next state IDLE, res_valid=0 and in_ready=1 in the following cycle.
  - A sample can be accepted one cycle after the result handshake; never in the same cycle.
- res_* fields are registered. Outside HOLD their values are don't-care to the consumer; implement them as the last completed result.
- clear=1 at an edge:
  - next state IDLE, counters zeroed, res_valid=0.
  - Overrides a simultaneous accept, and a simultaneous res_ready handshake, which is then dropped.
- Arithmetic: all unsigned; count never exceeds WINDOW; ties ≤ WINDOW fits CNT_W.
- in_valid gaps (in_valid=0) hold all state; no timeout.

Decomposition:
- Package mag_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_HOLD=2'd2;
  - default WIDTH/WINDOW constants.
- Sub-module mag_cmp(eq, gt, lt, a, b), parameterised by WIDTH, purely combinational; exactly one output is high.
- mag_window_minmax instantiates mag_cmp twice: sample vs max, and sample vs min.

Test Plan (WIDTH=4, WINDOW=4 unless noted):
- Reset: drop rst_n asynchronously after 2 accepted samples -> immediately res_valid=0, in_ready=1, res_*=0. A subsequent window of 4 reports only the new samples.
- Basic window: accept 5,3,9,2 back-to-back -> res_valid=1 the cycle after the 4th accept; max=9, max_idx=2, min=2, min_idx=3, ties=1.
- Ties / first occurrence: 7,7,1,7 -> max=7, max_idx=0, ties=3, min=1, min_idx=2. Then 4,4,4,4 -> max=min=4, both idx=0, ties=4.
- Backpressure:
  - Result pending with res_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 throughout, res_* stable, no sample consumed.
  - res_ready=1 for one cycle -> next cycle res_valid=0, in_ready=1; the next window starts at index 0.
- Clear: accept 12,1, then clear=1 together with in_valid=1 (that sample dropped), then 0,15,15,0 -> max=15, max_idx=1, ties=2, min=0, min_idx=0.
- Boundaries:
  - WINDOW=1 build: each accepted sample gives res_valid next cycle with max=min=sample, idx=0, ties=1.
  - WINDOW=4 with in_valid toggled every other cycle over 15,0,15,0 -> max=15/idx0, min=0/idx1, ties=2.
